// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants and FSM encodings for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  localparam int RWIDTH = 5;
  localparam int WORD_W = 32;

  localparam logic [RWIDTH-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use detector: the instruction in EX is a load whose
// destination is read by the instruction in ID.
module hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int rwidth = RWIDTH
) (
  input  logic [rwidth-1:0] i_idRs,
  input  logic [rwidth-1:0] i_idRt,
  input  logic              i_idUsesRt,
  input  logic              i_exMemRead,
  input  logic [rwidth-1:0] i_exWriteReg,
  output logic              o_loadUse
);

  logic w_destLive;
  logic w_rsHit;
  logic w_rtHit;

  // Register zero is hardwired, so a load targeting it never creates a hazard.
  assign w_destLive = (i_exWriteReg != rwidth'(REG_ZERO));
  assign w_rsHit    = (i_exWriteReg == i_idRs);
  assign w_rtHit    = i_idUsesRt && (i_exWriteReg == i_idRt);
  assign o_loadUse  = i_exMemRead && w_destLive && (w_rsHit || w_rtHit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory freeze, load-use bubble,
// branch/jump flush, plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int rwidth      = RWIDTH,
  parameter int MEM_LATENCY = 3,
  parameter int CNT_W       = WORD_W
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [rwidth-1:0] ID_Rs,
  input  logic [rwidth-1:0] ID_Rt,
  input  logic              ID_UsesRt,
  input  logic              ID_BranchTaken,
  input  logic              ID_Jump,
  input  logic              EX_MemRead,
  input  logic [rwidth-1:0] EX_WriteReg,
  input  logic              MEM_MemRead,
  input  logic              MEM_MemWrite,
  output logic              PC_Write,
  output logic              IF_ID_Write,
  output logic              IF_ID_Flush,
  output logic              ID_EX_Bubble,
  output logic              EX_MEM_Write,
  output logic              MEM_WB_Bubble,
  output logic [1:0]        Ctrl_State,
  output logic [CNT_W-1:0]  Stall_Count
);

  localparam int            CW       = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;
  localparam bit            MULTI    = (MEM_LATENCY > 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'((MEM_LATENCY > 1) ? (MEM_LATENCY - 2) : 0);

  ctrl_state_t      r_state;
  ctrl_state_t      w_nextState;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_nextCnt;
  logic [CNT_W-1:0] r_stallCount;

  logic w_memop;
  logic w_lu;
  logic w_redirect;
  logic w_freeze;
  logic w_pcWrite;
  logic w_ifIdWrite;
  logic w_ifIdFlush;
  logic w_idExBubble;
  logic w_exMemWrite;
  logic w_memWbBubble;

  hazard_detect #(
    .rwidth(rwidth)
  ) u_hazardDetect (
    .i_idRs      (ID_Rs),
    .i_idRt      (ID_Rt),
    .i_idUsesRt  (ID_UsesRt),
    .i_exMemRead (EX_MemRead),
    .i_exWriteReg(EX_WriteReg),
    .o_loadUse   (w_lu)
  );

  assign w_memop    = MEM_MemRead || MEM_MemWrite;
  assign w_redirect = ID_BranchTaken || ID_Jump;
  // The last WAIT cycle (cnt==0) is the release cycle and is not frozen.
  assign w_freeze   = ((r_state == RUN) && w_memop && MULTI) ||
                      ((r_state == WAIT) && (r_cnt != '0));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    case (r_state)
      RUN: begin
        if (w_memop && MULTI) begin
          w_nextState = WAIT;
          w_nextCnt   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (r_cnt != '0) begin
          w_nextCnt = r_cnt - CW'(1);
        end else begin
          w_nextState = RUN;
        end
      end
      default: begin
        w_nextState = RUN;
        w_nextCnt   = '0;
      end
    endcase
  end

  // Priority: reset forcing, then freeze, then load-use, then redirect.
  always_comb begin
    w_pcWrite     = 1'b1;
    w_ifIdWrite   = 1'b1;
    w_ifIdFlush   = 1'b0;
    w_idExBubble  = 1'b0;
    w_exMemWrite  = 1'b1;
    w_memWbBubble = 1'b0;
    if (!Resetn) begin
      w_pcWrite     = 1'b0;
      w_ifIdWrite   = 1'b0;
      w_ifIdFlush   = 1'b1;
      w_idExBubble  = 1'b1;
      w_memWbBubble = 1'b1;
    end else if (w_freeze) begin
      w_pcWrite     = 1'b0;
      w_ifIdWrite   = 1'b0;
      w_exMemWrite  = 1'b0;
      w_memWbBubble = 1'b1;
    end else if (w_lu) begin
      w_pcWrite    = 1'b0;
      w_ifIdWrite  = 1'b0;
      w_idExBubble = 1'b1;
    end else if (w_redirect) begin
      w_ifIdFlush = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_stallCount <= '0;
    end else if (!w_pcWrite && (r_stallCount != '1)) begin
      r_stallCount <= r_stallCount + CNT_W'(1);
    end
  end

  assign PC_Write      = w_pcWrite;
  assign IF_ID_Write   = w_ifIdWrite;
  assign IF_ID_Flush   = w_ifIdFlush;
  assign ID_EX_Bubble  = w_idExBubble;
  assign EX_MEM_Write  = w_exMemWrite;
  assign MEM_WB_Bubble = w_memWbBubble;
  assign Ctrl_State    = r_state;
  assign Stall_Count   = r_stallCount;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: dutA uses MEM_LATENCY=3, dutB uses
// MEM_LATENCY=1 with a 2-bit stall counter so saturation is reachable.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesRt;
    logic       br;
    logic       jmp;
    logic       exRd;
    logic [4:0] exWr;
    logic       memRd;
    logic       memWr;
  } stim_t;

  typedef struct {
    int          which;
    string       name;
    logic [5:0]  ctl;
    logic [1:0]  st;
    logic [31:0] cnt;
  } exp_t;

  // Control bundle order: {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Write, MEM_WB_Bubble}
  localparam logic [5:0] NORM = 6'b110010;
  localparam logic [5:0] RSTO = 6'b001111;
  localparam logic [5:0] FRZ  = 6'b000001;
  localparam logic [5:0] LU   = 6'b000110;
  localparam logic [5:0] RDR  = 6'b111010;

  logic        Clock;
  logic        Resetn;
  stim_t       sA;
  stim_t       sB;
  logic [5:0]  aCtl;
  logic [5:0]  bCtl;
  logic [1:0]  aState;
  logic [1:0]  bState;
  logic [31:0] aCount;
  logic [1:0]  bCount;

  exp_t expQ[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  pipeline_hazard_ctrl #(.rwidth(5), .MEM_LATENCY(3), .CNT_W(32)) dutA (
    .Clock(Clock), .Resetn(Resetn),
    .ID_Rs(sA.rs), .ID_Rt(sA.rt), .ID_UsesRt(sA.usesRt),
    .ID_BranchTaken(sA.br), .ID_Jump(sA.jmp),
    .EX_MemRead(sA.exRd), .EX_WriteReg(sA.exWr),
    .MEM_MemRead(sA.memRd), .MEM_MemWrite(sA.memWr),
    .PC_Write(aCtl[5]), .IF_ID_Write(aCtl[4]), .IF_ID_Flush(aCtl[3]),
    .ID_EX_Bubble(aCtl[2]), .EX_MEM_Write(aCtl[1]), .MEM_WB_Bubble(aCtl[0]),
    .Ctrl_State(aState), .Stall_Count(aCount)
  );

  pipeline_hazard_ctrl #(.rwidth(5), .MEM_LATENCY(1), .CNT_W(2)) dutB (
    .Clock(Clock), .Resetn(Resetn),
    .ID_Rs(sB.rs), .ID_Rt(sB.rt), .ID_UsesRt(sB.usesRt),
    .ID_BranchTaken(sB.br), .ID_Jump(sB.jmp),
    .EX_MemRead(sB.exRd), .EX_WriteReg(sB.exWr),
    .MEM_MemRead(sB.memRd), .MEM_MemWrite(sB.memWr),
    .PC_Write(bCtl[5]), .IF_ID_Write(bCtl[4]), .IF_ID_Flush(bCtl[3]),
    .ID_EX_Bubble(bCtl[2]), .EX_MEM_Write(bCtl[1]), .MEM_WB_Bubble(bCtl[0]),
    .Ctrl_State(bState), .Stall_Count(bCount)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: actual=still running required=finished");
    $fatal(1, "[TB] timeout");
  end

  function automatic stim_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                               input logic br, input logic jmp, input logic exRd,
                               input logic [4:0] exWr, input logic memRd, input logic memWr);
    stim_t s;
    s.rs = rs; s.rt = rt; s.usesRt = usesRt; s.br = br; s.jmp = jmp;
    s.exRd = exRd; s.exWr = exWr; s.memRd = memRd; s.memWr = memWr;
    return s;
  endfunction

  function automatic stim_t rnd();
    logic [31:0] r;
    r = $urandom;
    return r[20:0];
  endfunction

  // Drive one cycle of inputs just after the rising edge and queue what the
  // monitor must see at the following falling edge.
  task automatic applyStimulus(input int which, input logic rstn, input stim_t s, input string name,
                               input logic [5:0] ctl, input logic [1:0] st, input logic [31:0] cnt);
    exp_t x;
    @(posedge Clock);
    #1;
    Resetn = rstn;
    if (which == 0) begin
      sA = s;
      sB = '0;
    end else begin
      sB = s;
      sA = '0;
    end
    x.which = which; x.name = name; x.ctl = ctl; x.st = st; x.cnt = cnt;
    expQ.push_back(x);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: whenever an expectation is pending, compare it at the falling edge.
  initial begin
    forever begin
      @(negedge Clock);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        if (e.which == 0) begin
          checkOutput({e.name, ".ctl"},   {26'd0, aCtl},   {26'd0, e.ctl});
          checkOutput({e.name, ".state"}, {30'd0, aState}, {30'd0, e.st});
          checkOutput({e.name, ".count"}, aCount,          e.cnt);
        end else begin
          checkOutput({e.name, ".ctl"},   {26'd0, bCtl},   {26'd0, e.ctl});
          checkOutput({e.name, ".state"}, {30'd0, bState}, {30'd0, e.st});
          checkOutput({e.name, ".count"}, {30'd0, bCount}, e.cnt);
        end
      end
    end
  end

  stim_t idle;
  stim_t luRs;
  stim_t allA;

  initial begin
    Resetn = 1'b0;
    sA     = '0;
    sB     = '0;
    idle   = '0;
    luRs   = mk(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    allA   = mk(5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);

    // Reset with random inputs, then release
    applyStimulus(0, 1'b0, rnd(), "rst0", RSTO, 2'd0, 32'd0);
    applyStimulus(0, 1'b0, rnd(), "rst1", RSTO, 2'd0, 32'd0);
    applyStimulus(0, 1'b1, idle,  "rel",  NORM, 2'd0, 32'd0);

    // Load-use on rs, zero-register load, unused rt, used rt
    applyStimulus(0, 1'b1, luRs, "luRs", LU, 2'd0, 32'd0);
    applyStimulus(0, 1'b1, idle, "luClr", NORM, 2'd0, 32'd1);
    applyStimulus(0, 1'b1, mk(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0),
                  "luR0", NORM, 2'd0, 32'd1);
    applyStimulus(0, 1'b1, mk(5'd3, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0),
                  "rtUnused", NORM, 2'd0, 32'd1);
    applyStimulus(0, 1'b1, mk(5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0),
                  "luRt", LU, 2'd0, 32'd1);
    applyStimulus(0, 1'b1, idle, "luRtClr", NORM, 2'd0, 32'd2);

    // Redirects
    applyStimulus(0, 1'b1, mk(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0),
                  "branch", RDR, 2'd0, 32'd2);
    applyStimulus(0, 1'b1, mk(5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0),
                  "jump", RDR, 2'd0, 32'd2);

    // Single load in MEM: two freeze cycles then release
    applyStimulus(0, 1'b1, mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0), "ld.f0",  FRZ,  2'd0, 32'd2);
    applyStimulus(0, 1'b1, mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0), "ld.f1",  FRZ,  2'd1, 32'd3);
    applyStimulus(0, 1'b1, mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0), "ld.rel", NORM, 2'd1, 32'd4);
    applyStimulus(0, 1'b1, idle, "ld.after", NORM, 2'd0, 32'd4);

    // Back-to-back store then load
    applyStimulus(0, 1'b1, mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1), "st.f0",  FRZ,  2'd0, 32'd4);
    applyStimulus(0, 1'b1, mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1), "st.f1",  FRZ,  2'd1, 32'd5);
    applyStimulus(0, 1'b1, mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1), "st.rel", NORM, 2'd1, 32'd6);
    applyStimulus(0, 1'b1, mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0), "b2b.f0",  FRZ,  2'd0, 32'd6);
    applyStimulus(0, 1'b1, mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0), "b2b.f1",  FRZ,  2'd1, 32'd7);
    applyStimulus(0, 1'b1, mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0), "b2b.rel", NORM, 2'd1, 32'd8);
    applyStimulus(0, 1'b1, idle, "b2b.after", NORM, 2'd0, 32'd8);

    // Priority: freeze wins, then load-use, then the branch flush
    applyStimulus(0, 1'b1, allA, "pri.f0",  FRZ, 2'd0, 32'd8);
    applyStimulus(0, 1'b1, allA, "pri.f1",  FRZ, 2'd1, 32'd9);
    applyStimulus(0, 1'b1, allA, "pri.lu",  LU,  2'd1, 32'd10);
    applyStimulus(0, 1'b1, mk(5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0),
                  "pri.br", RDR, 2'd0, 32'd11);
    applyStimulus(0, 1'b1, idle, "pri.after", NORM, 2'd0, 32'd11);

    // Reset in the second freeze cycle abandons the access
    applyStimulus(0, 1'b1, mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0), "mid.f0",  FRZ,  2'd0, 32'd11);
    applyStimulus(0, 1'b0, mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0), "mid.rst", RSTO, 2'd0, 32'd0);
    applyStimulus(0, 1'b1, idle, "mid.rel",  NORM, 2'd0, 32'd0);
    applyStimulus(0, 1'b1, idle, "mid.idle", NORM, 2'd0, 32'd0);

    // MEM_LATENCY=1: memops never freeze; 2-bit counter saturates under load-use
    applyStimulus(1, 1'b1, mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0), "L1.ld",  NORM, 2'd0, 32'd0);
    applyStimulus(1, 1'b1, mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1), "L1.st",  NORM, 2'd0, 32'd0);
    applyStimulus(1, 1'b1, mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0), "L1.ld2", NORM, 2'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1'b1, mk(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0),
                    $sformatf("L1.lu%0d", i), LU, 2'd0, (i < 3) ? i : 3);
    end
    applyStimulus(1, 1'b1, idle, "L1.sat", NORM, 2'd0, 32'd3);

    @(negedge Clock);
    @(negedge Clock);
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: actual=%0d pending required=0 pending", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the write and hold enables of PC, IF/ID, ID/EX, EX/MEM and MEM/WB, covering three cases:
- load-use hazards, resolved by a one-cycle bubble;
- taken branches and jumps, resolved by an IF/ID flush;
- multi-cycle data-memory access, resolved by a counted freeze of the whole front of the pipe.

It also keeps a saturating stall-cycle counter for performance measurement.

Parameters:
rwidth, 5, register-address width
MEM_LATENCY, 3, cycles a load/store occupies MEM stage (>=1; 1 means no freeze)
CNT_W, 32, width of Stall_Count

Ports:
Clock  in  1  pipeline clock, rising edge
Resetn  in  1  asynchronous active-low reset
ID_Rs  in  rwidth  rs field of instruction in ID
ID_Rt  in  rwidth  rt field of instruction in ID
ID_UsesRt  in  1  ID instruction reads rt
ID_BranchTaken  in  1  branch resolved taken in ID
ID_Jump  in  1  jump decoded in ID
EX_MemRead  in  1  instruction in EX is a load
EX_WriteReg  in  rwidth  destination register of instruction in EX
MEM_MemRead  in  1  instruction in MEM is a load
MEM_MemWrite  in  1  instruction in MEM is a store
PC_Write  out  1  PC update enable
IF_ID_Write  out  1  IF/ID load enable
IF_ID_Flush  out  1  IF/ID clear to NOP
ID_EX_Bubble  out  1  ID/EX loads zero control (NOP)
EX_MEM_Write  out  1  EX/MEM load enable (0 = hold)
MEM_WB_Bubble  out  1  MEM/WB loads zero control
Ctrl_State  out  2  current FSM state (debug)
Stall_Count  out  CNT_W  cycles with PC_Write=0

Behaviour:
- Interface: one clock, Clock; reset is asynchronous and active-low, Resetn.
- FSM states: RUN=2'd0, WAIT=2'd1. Register cnt has width clog2(MEM_LATENCY), minimum 1.
- Reset (Resetn=0, asynchronous):
  - state=RUN, cnt=0, Stall_Count=0.
  - While Resetn=0, outputs are forced: PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Bubble=1, EX_MEM_Write=1, MEM_WB_Bubble=1.
  - Reset during WAIT abandons the access; the first cycle after release is RUN.
- Definitions:
  - memop = MEM_MemRead | MEM_MemWrite.
  - lu = EX_MemRead & (EX_WriteReg!=0) & (EX_WriteReg==ID_Rs | (ID_UsesRt & EX_WriteReg==ID_Rt)).
  - redirect = ID_BranchTaken | ID_Jump.
- Outputs are a combinational decode of state, cnt and inputs (same-cycle response, zero latency). Priority is freeze > lu > redirect.
- Freeze is asserted when (RUN & memop & MEM_LATENCY>1) or (WAIT & cnt!=0). During freeze:
  - PC_Write=0, IF_ID_Write=0, EX_MEM_Write=0, MEM_WB_Bubble=1;
  - ID_EX_Bubble=0 (ID/EX also holds);
  - IF_ID_Flush=0; a pending redirect is re-evaluated after release.
- Load-use (no freeze, lu=1): PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, EX_MEM_Write=1, IF_ID_Flush=0. The stall clears itself next cycle because the bubble makes EX_MemRead=0. No state is needed.
- Redirect (no freeze, no lu): IF_ID_Flush=1. All write enables =1, bubbles=0.
- Otherwise: all enables =1, Flush=0, bubbles=0.
- FSM transitions:
  - RUN -> WAIT when memop & MEM_LATENCY>1; cnt<=MEM_LATENCY-2.
  - WAIT & cnt!=0 -> WAIT, cnt<=cnt-1.
  - WAIT & cnt==0 -> RUN. This cycle is the release cycle: no freeze, the MEM op completes and EX/MEM advances.
  - Net effect: every memop occupies MEM for exactly MEM_LATENCY cycles with MEM_LATENCY-1 freeze cycles.
  - Back-to-back memops: the release cycle lands in RUN. The next memop is detected fresh in its first MEM cycle.
  - While frozen, memop inputs are stable by construction; no re-trigger occurs.
- Stall_Count increments each cycle PC_Write=0 while Resetn=1. It saturates at all-ones and never wraps.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - state encodings RUN/WAIT;
  - the constant REG_ZERO=5'd0;
  - the shared rwidth/word constants.
- One natural sub-module: hazard_detect, the purely combinational lu compare. The FSM, counter and output decode stay in the top module.

Test Plan:
- Reset: hold Resetn=0 with random inputs -> PC_Write=0, IF_ID_Flush=1, ID_EX_Bubble=1, Stall_Count=0; release -> Ctrl_State=0.
- Load-use: EX_MemRead=1, EX_WriteReg=8, ID_Rs=8 -> one cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1. With EX_WriteReg=0 -> no stall. With ID_Rt=8 and ID_UsesRt=0 -> no stall.
- Memory freeze, MEM_LATENCY=3: MEM_MemRead=1 held -> EX_MEM_Write=0 for exactly 2 cycles, then 1. Ctrl_State sequence 0,1,1,0. Stall_Count=2.
- Back-to-back: store followed immediately by load in MEM, MEM_LATENCY=3 -> two freeze windows of 2 cycles separated by one release cycle. Stall_Count=4.
- Priority: memop, lu and ID_BranchTaken all asserted together -> freeze outputs only (IF_ID_Flush=0). After release, lu stall occurs first; branch flush is seen once lu clears.
- Reset mid-WAIT: drop Resetn in the second freeze cycle -> state=RUN, cnt=0 immediately. After release with no memop -> all enables =1. Also run MEM_LATENCY=1 with a constant memop -> never leaves RUN and Stall_Count stays 0.
